// File: rtl/led_fade_sequencer.sv
// led_fade_sequencer
// Steps through a writable RGB palette. For each entry the brightness ramps
// up, holds at full scale for a set number of periods, then ramps back down.
// One brightness step is taken per tick_i, which is the brightness
// modulator's period-done pulse. Every output comes straight from a register.
module led_fade_sequencer #(
   parameter int NUM_COLORS   = 8,
   parameter int BRTNS_W      = 5,
   parameter int HOLD_PERIODS = 16,
   parameter int IDX_W        = $clog2(NUM_COLORS)
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               en_i,
   input  logic               tick_i,
   input  logic               wr_en_i,
   input  logic [IDX_W-1:0]   wr_addr_i,
   input  logic [23:0]        wr_data_i,
   output logic [23:0]        color_o,
   output logic [BRTNS_W-1:0] brtns_o,
   output logic [1:0]         state_o,
   output logic [IDX_W-1:0]   idx_o,
   output logic               wrap_o
);

   localparam logic [BRTNS_W-1:0] BMAX      = '1;
   localparam int                 HC_W      = (HOLD_PERIODS > 1) ? $clog2(HOLD_PERIODS) : 1;
   localparam logic [HC_W-1:0]    HOLD_LAST = HC_W'(HOLD_PERIODS - 1);
   localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(NUM_COLORS - 1);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_FADE_IN  = 2'd1,
      ST_HOLD     = 2'd2,
      ST_FADE_OUT = 2'd3
   } state_t;

   // Power-on palette; entries beyond the eighth start black.
   function automatic logic [23:0] default_color(input int i);
      case (i)
         0:       return 24'hFF0000;
         1:       return 24'h00FF00;
         2:       return 24'h0000FF;
         3:       return 24'hFFFF00;
         4:       return 24'hFF00FF;
         5:       return 24'h00FFFF;
         6:       return 24'hFFFFFF;
         7:       return 24'hFF8000;
         default: return 24'h000000;
      endcase
   endfunction

   state_t               state_reg, state_next;
   logic [BRTNS_W-1:0]   brtns_reg, brtns_next;
   logic [23:0]          color_reg, color_next;
   logic [IDX_W-1:0]     idx_reg, idx_next;
   logic [HC_W-1:0]      hold_cnt_reg, hold_cnt_next;
   logic                 wrap_reg, wrap_next;
   logic                 load_color;
   logic [IDX_W-1:0]     load_idx;
   logic [23:0]          palette [NUM_COLORS];

   // Palette held in registers (each entry must restore its own default on
   // reset). An address past the last entry matches no entry and is dropped.
   for (genvar gi = 0; gi < NUM_COLORS; gi++) begin : g_palette
      localparam logic [23:0] RST_COLOR = default_color(gi);
      logic [23:0] entry_reg;

      // Entry register: default on reset, write data on an address match.
      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            entry_reg <= RST_COLOR;
         end else if (wr_en_i && (wr_addr_i == IDX_W'(gi))) begin
            entry_reg <= wr_data_i;
         end
      end

      assign palette[gi] = entry_reg;
   end

   // Sequencer state register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_reg    <= ST_IDLE;
         brtns_reg    <= '0;
         color_reg    <= '0;
         idx_reg      <= '0;
         hold_cnt_reg <= '0;
         wrap_reg     <= 1'b0;
      end else begin
         state_reg    <= state_next;
         brtns_reg    <= brtns_next;
         color_reg    <= color_next;
         idx_reg      <= idx_next;
         hold_cnt_reg <= hold_cnt_next;
         wrap_reg     <= wrap_next;
      end
   end

   // Next-state logic: everything advances only on a tick.
   always_comb begin
      state_next    = state_reg;
      brtns_next    = brtns_reg;
      color_next    = color_reg;
      idx_next      = idx_reg;
      hold_cnt_next = hold_cnt_reg;
      wrap_next     = 1'b0;
      load_color    = 1'b0;
      load_idx      = idx_reg;

      if (tick_i) begin
         case (state_reg)
            ST_IDLE: begin
               if (en_i) begin
                  state_next = ST_FADE_IN;
                  load_color = 1'b1;
               end
            end
            ST_FADE_IN: begin
               if (!en_i) begin
                  state_next = ST_FADE_OUT;
               end else if (brtns_reg == BMAX) begin
                  state_next    = ST_HOLD;
                  hold_cnt_next = '0;
               end else begin
                  brtns_next = brtns_reg + 1'b1;
               end
            end
            ST_HOLD: begin
               if (!en_i || (hold_cnt_reg == HOLD_LAST)) begin
                  state_next = ST_FADE_OUT;
               end else begin
                  hold_cnt_next = hold_cnt_reg + 1'b1;
               end
            end
            ST_FADE_OUT: begin
               // The ramp down always finishes, whatever en_i does.
               if (brtns_reg != '0) begin
                  brtns_next = brtns_reg - 1'b1;
               end else begin
                  if (idx_reg == IDX_LAST) begin
                     idx_next  = '0;
                     wrap_next = 1'b1;
                  end else begin
                     idx_next = idx_reg + 1'b1;
                  end
                  load_idx = idx_next;
                  if (en_i) begin
                     state_next = ST_FADE_IN;
                     load_color = 1'b1;
                  end else begin
                     state_next = ST_IDLE;
                  end
               end
            end
            default: state_next = ST_IDLE;
         endcase
      end

      // A write landing on the entry being loaded wins over the stored value.
      if (load_color) begin
         if (wr_en_i && (wr_addr_i == load_idx)) begin
            color_next = wr_data_i;
         end else begin
            color_next = palette[load_idx];
         end
      end
   end

   assign color_o = color_reg;
   assign brtns_o = brtns_reg;
   assign state_o = state_reg;
   assign idx_o   = idx_reg;
   assign wrap_o  = wrap_reg;

endmodule

// File: tb/tb_led_fade_sequencer.sv
// Directed bench for led_fade_sequencer. Three instances cover the default
// 8-entry palette (HOLD_PERIODS=2), a 2-entry palette for wrap-around and a
// 6-entry palette for out-of-range writes. Each instance has its own tick so
// the others stay still while one is exercised.
module tb_led_fade_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic        tick_a = 1'b0;
   logic        tick_b = 1'b0;
   logic        tick_c = 1'b0;
   logic        wr_en = 1'b0;
   logic [2:0]  wr_addr = '0;
   logic [23:0] wr_data = '0;
   logic        wr_en_b = 1'b0;
   logic [0:0]  wr_addr_b = '0;

   logic [23:0] color_a, color_b, color_c;
   logic [4:0]  brtns_a;
   logic [1:0]  brtns_b, brtns_c;
   logic [1:0]  state_a, state_b, state_c;
   logic [2:0]  idx_a, idx_c;
   logic [0:0]  idx_b;
   logic        wrap_a, wrap_b, wrap_c;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   led_fade_sequencer #(.NUM_COLORS(8), .BRTNS_W(5), .HOLD_PERIODS(2)) dut_a (
      .clk_i(clk), .rst_i(rst), .en_i(en), .tick_i(tick_a),
      .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
      .color_o(color_a), .brtns_o(brtns_a), .state_o(state_a),
      .idx_o(idx_a), .wrap_o(wrap_a)
   );

   led_fade_sequencer #(.NUM_COLORS(2), .BRTNS_W(2), .HOLD_PERIODS(1)) dut_b (
      .clk_i(clk), .rst_i(rst), .en_i(en), .tick_i(tick_b),
      .wr_en_i(wr_en_b), .wr_addr_i(wr_addr_b), .wr_data_i(wr_data),
      .color_o(color_b), .brtns_o(brtns_b), .state_o(state_b),
      .idx_o(idx_b), .wrap_o(wrap_b)
   );

   led_fade_sequencer #(.NUM_COLORS(6), .BRTNS_W(2), .HOLD_PERIODS(1)) dut_c (
      .clk_i(clk), .rst_i(rst), .en_i(en), .tick_i(tick_c),
      .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
      .color_o(color_c), .brtns_o(brtns_c), .state_o(state_c),
      .idx_o(idx_c), .wrap_o(wrap_c)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
      if (obs === exp) $display("check %-14s value=%h ok", tag, obs);
   endtask

   // One clock with optional tick (which: 0=a, 1=b, 2=c) and optional write.
   // Inputs change on the falling edge; outputs are read on the next one.
   task automatic step(input int which, input bit do_tick, input bit do_wr,
                       input logic [2:0] addr, input logic [23:0] data);
      @(negedge clk);
      if (do_tick) begin
         case (which)
            0:       tick_a = 1'b1;
            1:       tick_b = 1'b1;
            default: tick_c = 1'b1;
         endcase
      end
      wr_en   = do_wr;
      wr_addr = addr;
      wr_data = data;
      @(negedge clk);
      tick_a = 1'b0;
      tick_b = 1'b0;
      tick_c = 1'b0;
      wr_en  = 1'b0;
   endtask

   task automatic ticks(input int which, input int n);
      for (int i = 0; i < n; i++) step(which, 1'b1, 1'b0, 3'd0, 24'h0);
   endtask

   initial begin
      logic [23:0] pal_c [6];
      pal_c = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFFFF00, 24'hFF00FF, 24'h00FFFF};

      // Reset, then ticks with en low: nothing leaves IDLE.
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("rst_state", 32'(state_a), 32'd0);
      check("rst_wrap", 32'(wrap_a), 32'd0);
      ticks(0, 5);
      check("idle_state", 32'(state_a), 32'd0);
      check("idle_brtns", 32'(brtns_a), 32'd0);
      check("idle_color", 32'(color_a), 32'h000000);
      check("idle_idx", 32'(idx_a), 32'd0);

      // Full fade cycle on entry 0 with HOLD_PERIODS=2.
      en = 1'b1;
      ticks(0, 1);
      check("t1_state", 32'(state_a), 32'd1);
      check("t1_color", 32'(color_a), 32'hFF0000);
      check("t1_brtns", 32'(brtns_a), 32'd0);
      ticks(0, 10);
      check("t11_brtns", 32'(brtns_a), 32'd10);
      repeat (4) @(negedge clk);
      check("notick_brtns", 32'(brtns_a), 32'd10);
      ticks(0, 21);
      check("t32_brtns", 32'(brtns_a), 32'd31);
      check("t32_state", 32'(state_a), 32'd1);
      ticks(0, 1);
      check("t33_state", 32'(state_a), 32'd2);
      check("t33_brtns", 32'(brtns_a), 32'd31);
      ticks(0, 1);
      check("t34_state", 32'(state_a), 32'd2);
      ticks(0, 1);
      check("t35_state", 32'(state_a), 32'd3);
      check("t35_brtns", 32'(brtns_a), 32'd31);
      ticks(0, 31);
      check("t66_brtns", 32'(brtns_a), 32'd0);
      check("t66_state", 32'(state_a), 32'd3);
      check("t66_idx", 32'(idx_a), 32'd0);
      ticks(0, 1);
      check("t67_idx", 32'(idx_a), 32'd1);
      check("t67_color", 32'(color_a), 32'h00FF00);
      check("t67_state", 32'(state_a), 32'd1);
      check("t67_wrap", 32'(wrap_a), 32'd0);

      // Enable dropped during HOLD: fade-out completes, then IDLE.
      ticks(0, 32);
      check("h_state", 32'(state_a), 32'd2);
      en = 1'b0;
      ticks(0, 1);
      check("drop_state", 32'(state_a), 32'd3);
      check("drop_brtns", 32'(brtns_a), 32'd31);
      ticks(0, 31);
      check("drop_ramp0", 32'(brtns_a), 32'd0);
      check("drop_st3", 32'(state_a), 32'd3);
      ticks(0, 1);
      check("drop_idle", 32'(state_a), 32'd0);
      check("drop_idx", 32'(idx_a), 32'd2);
      check("drop_color", 32'(color_a), 32'h00FF00);
      ticks(0, 1);
      check("drop_stay", 32'(state_a), 32'd0);

      // Two-entry palette: wrap back to entry 0 pulses wrap_o for one cycle.
      en = 1'b1;
      ticks(1, 1);
      check("b_color0", 32'(color_b), 32'hFF0000);
      ticks(1, 9);
      check("b_idx1", 32'(idx_b), 32'd1);
      check("b_color1", 32'(color_b), 32'h00FF00);
      check("b_wrap_lo", 32'(wrap_b), 32'd0);
      ticks(1, 8);
      check("b_fo_state", 32'(state_b), 32'd3);
      check("b_fo_brtns", 32'(brtns_b), 32'd0);
      ticks(1, 1);
      check("b_wrap_hi", 32'(wrap_b), 32'd1);
      check("b_wrap_idx", 32'(idx_b), 32'd0);
      check("b_wrap_color", 32'(color_b), 32'hFF0000);
      @(negedge clk);
      check("b_wrap_pulse", 32'(wrap_b), 32'd0);

      // Six-entry palette: writes to addresses 6 and 7 are dropped.
      step(2, 1'b0, 1'b1, 3'd6, 24'h777777);
      step(2, 1'b0, 1'b1, 3'd7, 24'h888888);
      ticks(2, 1);
      check("c_color0", 32'(color_c), 32'hFF0000);
      for (int k = 1; k < 6; k++) begin
         ticks(2, 9);
         check("c_idx", 32'(idx_c), 32'(k));
         check("c_color", 32'(color_c), 32'(pal_c[k]));
      end
      ticks(2, 9);
      check("c_wrap_idx", 32'(idx_c), 32'd0);
      check("c_wrap", 32'(wrap_c), 32'd1);
      check("c_wrap_color", 32'(color_c), 32'hFF0000);

      // Palette write, bypass on load, and no effect on the shown colour.
      step(0, 1'b0, 1'b1, 3'd3, 24'h0A0B0C);
      step(0, 1'b1, 1'b1, 3'd2, 24'h123456);
      check("byp_state", 32'(state_a), 32'd1);
      check("byp_color", 32'(color_a), 32'h123456);
      step(0, 1'b1, 1'b1, 3'd2, 24'hABCDEF);
      check("wr_shown", 32'(color_a), 32'h123456);
      check("wr_brtns", 32'(brtns_a), 32'd1);
      ticks(0, 65);
      check("wr_idx3", 32'(idx_a), 32'd3);
      check("wr_color3", 32'(color_a), 32'h0A0B0C);

      // Reset pulsed mid fade-out between edges; palette back to defaults.
      ticks(0, 39);
      check("pre_rst_state", 32'(state_a), 32'd3);
      check("pre_rst_brtns", 32'(brtns_a), 32'd26);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("arst_brtns", 32'(brtns_a), 32'd0);
      check("arst_color", 32'(color_a), 32'h000000);
      check("arst_state", 32'(state_a), 32'd0);
      check("arst_idx", 32'(idx_a), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      ticks(0, 1);
      check("post_color0", 32'(color_a), 32'hFF0000);
      ticks(0, 66);
      check("post_color1", 32'(color_a), 32'h00FF00);
      ticks(0, 66);
      check("post_idx2", 32'(idx_a), 32'd2);
      check("post_color2", 32'(color_a), 32'h0000FF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
